hex_keypad_entry: RTL and testbench
===================================

Name: hex_keypad_entry

Overview:
- Input-side counterpart of the calculator's 8-digit multiplexed hex display.
- Scans a 4x4 active-low matrix keypad and debounces key presses.
- Each accepted key yields a one-cycle hex key event, and the digit is shifted into a 32-bit operand register. That register feeds the calculator core, and through it the display.

Parameters:
- SCAN_DIV, 50000, clk_g cycles each row is driven (row dwell). Must be ≥4.
- DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release. Must be ≥2.

Ports:
- clk_g  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- key_col  in  4  keypad columns, active-low, externally pulled up, asynchronous
- clr  in  1  synchronous clear of the operand entry
- entry_en  in  1  1 = accepted digits are shifted into operand
- key_row  out  4  row drive, one-hot active-low
- key_valid  out  1  one-cycle pulse per accepted key press
- key_code  out  4  hex value of the last accepted key; held between pulses
- operand  out  32  entered value, most recent digit in [3:0]
- digit_cnt  out  4  digits entered, 0..8
- ovf  out  1  sticky flag: a digit was dropped because 8 digits were already entered

Behaviour:
- Reset (asynchronous, rst_n=0):
  - key_row=4'b1110, key_valid=0, key_code=0, operand=0, digit_cnt=0, ovf=0
  - FSM=IDLE; dwell counter, row index and snapshot all cleared.
- Row scan:
  - The dwell counter counts 0..SCAN_DIV-1. The last count is the tick.
  - On each tick the row index advances 0→1→2→3→0.
  - key_row=~(4'b0001<<row_idx).
- Column sampling:
  - key_col passes through a 2-flop synchronizer.
  - At the tick, the synchronized inverted columns are written to snapshot[row_idx*4 +: 4] (1 = pressed).
  - The tick that writes row 3 raises scan_done for one cycle.
  - A full scan takes 4*SCAN_DIV cycles.
- Decode, evaluated at scan_done on the completed snapshot:
  - none = all bits 0.
  - single = exactly one bit set.
  - multi = two or more bits set.
  - Key map, index row*4+col: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = E,0,F,D.
- FSM (transitions only at scan_done):
  - IDLE:
    - single → DEB_PRESS, cand=code, stable=1.
    - none or multi → stay in IDLE.
  - DEB_PRESS:
    - Same single code → stable+1.
    - When stable reaches DEBOUNCE_SCANS → HELD, and accept fires on the same edge.
    - Any other result (different code, none, multi) → IDLE.
  - HELD:
    - none → DEB_REL, stable=1.
    - single or multi → stay in HELD. No new events.
  - DEB_REL:
    - none → stable+1; when stable reaches DEBOUNCE_SCANS → IDLE.
    - Any key → HELD (bounce on release produces no event).
- Accept action (single edge):
  - key_valid=1 for exactly one cycle and key_code=cand, whatever entry_en is.
  - Operand update, applied on the same edge:
    - clr=1: operand=0, digit_cnt=0, ovf=0; the digit is discarded. clr has priority.
    - entry_en=1 and digit_cnt<8: operand={operand[27:0],cand}, digit_cnt+1.
    - entry_en=1 and digit_cnt==8: operand unchanged, ovf=1.
    - entry_en=0: operand unchanged.
- clr without an accept: operand, digit_cnt and ovf cleared on the next edge. The FSM and scan are unaffected.
- Latency: a press stable from scan k is accepted at the scan_done of scan k+DEBOUNCE_SCANS-1. key_valid is high in the cycle after that scan_done edge.
- A key held indefinitely produces exactly one event. There is no auto-repeat.
- Reset mid-debounce or mid-hold: everything returns to reset values. A key still held after reset is accepted again after DEBOUNCE_SCANS scans.

Decomposition:
- Package calc_pkg holds:
  - the FSM state enum {IDLE, DEB_PRESS, HELD, DEB_REL}
  - the 16-entry KEYMAP constant
  - OPERAND_W=32 and MAX_DIGITS=8
- Sub-module keypad_scan holds the dwell counter, row driver, synchronizer and snapshot, and outputs snapshot[15:0] and scan_done.
- The top level holds the decode, FSM and operand register.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3; full scan = 16 cycles):
- After reset, no keys → key_row cycles 1110,1101,1011,0111 every 4 cycles; key_valid never asserts; operand=0.
- Hold row1/col2 ('6') for 6 scans, then release for 4 scans → exactly one key_valid, 3 scans after the first stable scan; key_code=6; operand=0x00000006; digit_cnt=1.
- Press 1,2,A,F,0,3,C,D in sequence with entry_en=1 → operand=0x12AF03CD, digit_cnt=8; a ninth key '9' → operand unchanged, ovf=1, key_valid still pulses with key_code=9.
- Bouncing press ('5' for 2 scans, none for 1, then '5' for 3 scans) → one event only, accepted on the 3rd scan of the second run; release bouncing inside DEB_REL → no second event.
- Two keys pressed in the same scan (row0/col0 and row2/col1) → no event; release one so that '1' alone is stable for 3 scans → key_code=1.
- clr asserted on the accept edge → key_valid=1, key_code=digit, operand=0, digit_cnt=0, ovf=0. rst_n pulsed while in HELD → all outputs at reset values next cycle.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the calculator keypad entry path
package calc_pkg;

    localparam int OPERAND_W  = 32;
    localparam int MAX_DIGITS = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } key_state_e;

    // Nibble i is the hex value of matrix position i = row*4 + col.
    localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

    function automatic logic [3:0] keymap_lookup(input logic [3:0] idx);
        return KEYMAP[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix row scanner with column synchronizer and scan snapshot
module keypad_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk_g,
    input  logic        rst_n,
    input  logic [3:0]  key_col,
    output logic [3:0]  key_row,
    output logic [15:0] snapshot,
    output logic        scan_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [3:0]       col_s1_q, col_s1_d;
    logic [3:0]       col_s2_q, col_s2_d;
    logic [15:0]      snap_q, snap_d;
    logic             scan_done_q, scan_done_d;
    logic             tick;

    assign tick = (dwell_q == CNT_W'(SCAN_DIV - 1));

    always_comb begin
        dwell_d     = tick ? '0 : dwell_q + 1'b1;
        row_idx_d   = tick ? row_idx_q + 2'd1 : row_idx_q;
        col_s1_d    = key_col;
        col_s2_d    = col_s1_q;
        snap_d      = snap_q;
        // Columns are active-low; store 1 = pressed for the row being driven.
        if (tick) begin
            snap_d[{row_idx_q, 2'b00} +: 4] = ~col_s2_q;
        end
        scan_done_d = tick && (row_idx_q == 2'd3);
    end

    always_ff @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q     <= '0;
            row_idx_q   <= 2'd0;
            col_s1_q    <= 4'hF;
            col_s2_q    <= 4'hF;
            snap_q      <= '0;
            scan_done_q <= 1'b0;
        end else begin
            dwell_q     <= dwell_d;
            row_idx_q   <= row_idx_d;
            col_s1_q    <= col_s1_d;
            col_s2_q    <= col_s2_d;
            snap_q      <= snap_d;
            scan_done_q <= scan_done_d;
        end
    end

    assign key_row   = ~(4'b0001 << row_idx_q);
    assign snapshot  = snap_q;
    assign scan_done = scan_done_q;

endmodule

// File: rtl/hex_keypad_entry.sv
// rtl/hex_keypad_entry.sv - debounced hex keypad entry feeding a 32-bit operand register
module hex_keypad_entry
    import calc_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                 clk_g,
    input  logic                 rst_n,
    input  logic [3:0]           key_col,
    input  logic                 clr,
    input  logic                 entry_en,
    output logic [3:0]           key_row,
    output logic                 key_valid,
    output logic [3:0]           key_code,
    output logic [OPERAND_W-1:0] operand,
    output logic [3:0]           digit_cnt,
    output logic                 ovf
);

    localparam int ST_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [15:0] snapshot;
    logic        scan_done;

    keypad_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk_g     (clk_g),
        .rst_n     (rst_n),
        .key_col   (key_col),
        .key_row   (key_row),
        .snapshot  (snapshot),
        .scan_done (scan_done)
    );

    logic [4:0] pop;
    logic [3:0] hit_idx;
    logic       is_none;
    logic       is_single;
    logic [3:0] dec_code;

    always_comb begin
        pop     = '0;
        hit_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (snapshot[i]) begin
                pop     = pop + 5'd1;
                hit_idx = 4'(i);
            end
        end
        is_none   = (pop == 5'd0);
        is_single = (pop == 5'd1);
        dec_code  = keymap_lookup(hit_idx);
    end

    key_state_e           state_q, state_d;
    logic [3:0]           cand_q, cand_d;
    logic [ST_W-1:0]      stable_q, stable_d;
    logic                 accept;

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        stable_d = stable_q;
        accept   = 1'b0;
        if (scan_done) begin
            case (state_q)
                IDLE: begin
                    if (is_single) begin
                        state_d  = DEB_PRESS;
                        cand_d   = dec_code;
                        stable_d = ST_W'(1);
                    end
                end
                DEB_PRESS: begin
                    if (is_single && (dec_code == cand_q)) begin
                        if (stable_q == ST_W'(DEBOUNCE_SCANS - 1)) begin
                            state_d = HELD;
                            accept  = 1'b1;
                        end else begin
                            stable_d = stable_q + 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (is_none) begin
                        state_d  = DEB_REL;
                        stable_d = ST_W'(1);
                    end
                end
                DEB_REL: begin
                    // Any key seen while releasing is bounce: back to HELD, no event.
                    if (is_none) begin
                        if (stable_q == ST_W'(DEBOUNCE_SCANS - 1)) begin
                            state_d = IDLE;
                        end else begin
                            stable_d = stable_q + 1'b1;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic                 key_valid_q, key_valid_d;
    logic [3:0]           key_code_q, key_code_d;
    logic [OPERAND_W-1:0] operand_q, operand_d;
    logic [3:0]           digit_cnt_q, digit_cnt_d;
    logic                 ovf_q, ovf_d;

    always_comb begin
        key_valid_d = accept;
        key_code_d  = accept ? cand_q : key_code_q;
        operand_d   = operand_q;
        digit_cnt_d = digit_cnt_q;
        ovf_d       = ovf_q;
        if (clr) begin
            operand_d   = '0;
            digit_cnt_d = '0;
            ovf_d       = 1'b0;
        end else if (accept && entry_en) begin
            if (digit_cnt_q < 4'(MAX_DIGITS)) begin
                operand_d   = {operand_q[OPERAND_W-5:0], cand_q};
                digit_cnt_d = digit_cnt_q + 4'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            stable_q    <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            operand_q   <= '0;
            digit_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            stable_q    <= stable_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            operand_q   <= operand_d;
            digit_cnt_q <= digit_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign operand   = operand_q;
    assign digit_cnt = digit_cnt_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// tb/tb_hex_keypad_entry.sv - scan-level reference model bench for hex_keypad_entry
module tb_hex_keypad_entry;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 3;

    logic        clk_g = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_col;
    logic        clr = 1'b0;
    logic        entry_en = 1'b0;
    logic [3:0]  key_row;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] operand;
    logic [3:0]  digit_cnt;
    logic        ovf;

    logic [15:0] keys = '0;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    hex_keypad_entry #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk_g     (clk_g),
        .rst_n     (rst_n),
        .key_col   (key_col),
        .clr       (clr),
        .entry_en  (entry_en),
        .key_row   (key_row),
        .key_valid (key_valid),
        .key_code  (key_code),
        .operand   (operand),
        .digit_cnt (digit_cnt),
        .ovf       (ovf)
    );

    always #5 clk_g = ~clk_g;

    // Passive matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        key_col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (key_row[r] === 1'b0) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[r*4+c]) key_col[c] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk_g) if (key_valid === 1'b1) pulses++;

    // Reference model: results of whole scans since the last mode change.
    int          KEYVAL[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    int          hist[$];
    bit          m_held;
    bit          pend_evt;
    logic [3:0]  pend_code;
    logic [3:0]  m_code;
    logic [31:0] m_op;
    int          m_cnt;
    bit          m_ovf;

    function automatic int classify(input logic [15:0] p);
        int n;
        n = $countones(p);
        if (n == 0) return -1;
        if (n > 1) return -2;
        for (int i = 0; i < 16; i++) if (p[i]) return KEYVAL[i];
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_held = 0; pend_evt = 0; pend_code = '0;
        m_code = '0; m_op = '0; m_cnt = 0; m_ovf = 0;
    endtask

    task automatic model_scan(input int r);
        bit same;
        logic [31:0] rv;
        hist.push_back(r);
        if (hist.size() >= DB) begin
            same = 1;
            for (int i = hist.size() - DB; i < hist.size(); i++)
                if (hist[i] != r) same = 0;
            if (!m_held && same && r >= 0) begin
                rv = r;
                pend_evt = 1; pend_code = rv[3:0]; m_held = 1; hist.delete();
            end else if (m_held && same && r == -1) begin
                m_held = 0; hist.delete();
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_g);
        #1;
        checks++; if (key_row !== 4'b1110) begin errors++; $display("FAIL rst_key_row got %b exp 1110", key_row); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_key_valid got %b exp 0", key_valid); end
        checks++; if (operand !== 32'h0 || digit_cnt !== 4'd0 || ovf !== 1'b0 || key_code !== 4'h0) begin
            errors++; $display("FAIL rst_regs got op=%h cnt=%0d ovf=%b code=%h exp zeros", operand, digit_cnt, ovf, key_code);
        end
        @(posedge clk_g);
        #2 rst_n = 1'b1;
    endtask

    // One full 16-cycle scan with a fixed key pattern, checked cycle by cycle.
    task automatic run_scan(input logic [15:0] pat, input logic en, input logic c);
        bit         exp_kv;
        logic [3:0] exp_row;
        @(negedge clk_g);
        keys = pat; entry_en = en; clr = c;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk_g);
            #1;
            exp_kv = 0;
            if (n == 1) begin
                clr = 1'b0;
                exp_kv = pend_evt;
                if (pend_evt) m_code = pend_code;
                if (c) begin
                    m_op = '0; m_cnt = 0; m_ovf = 0;
                end else if (pend_evt && en) begin
                    if (m_cnt < 8) begin m_op = {m_op[27:0], pend_code}; m_cnt++; end
                    else m_ovf = 1;
                end
                pend_evt = 0;
                checks++; if (key_code !== m_code) begin errors++; $display("FAIL key_code got %h exp %h", key_code, m_code); end
                checks++; if (operand !== m_op) begin errors++; $display("FAIL operand got %h exp %h", operand, m_op); end
                checks++; if (digit_cnt !== 4'(m_cnt)) begin errors++; $display("FAIL digit_cnt got %0d exp %0d", digit_cnt, m_cnt); end
                checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL ovf got %b exp %b", ovf, m_ovf); end
            end
            checks++; if (key_valid !== exp_kv) begin errors++; $display("FAIL key_valid cyc=%0d got %b exp %b", n, key_valid, exp_kv); end
            exp_row = 4'b0001 << ((n / 4) % 4);
            exp_row = ~exp_row;
            checks++; if (key_row !== exp_row) begin errors++; $display("FAIL key_row cyc=%0d got %b exp %b", n, key_row, exp_row); end
        end
        model_scan(classify(pat));
    endtask

    task automatic press_key(input int idx, input logic en);
        logic [15:0] p;
        p = 16'h1 << idx;
        repeat (DB) run_scan(p, en, 1'b0);
        repeat (DB) run_scan(16'h0, en, 1'b0);
    endtask

    task automatic test_reset();
        int p0;
        apply_reset();
        p0 = pulses;
        repeat (2) run_scan(16'h0, 1'b1, 1'b0);
        checks++; if (pulses != p0) begin errors++; $display("FAIL idle_pulses got %0d exp 0", pulses - p0); end
        checks++; if (operand !== 32'h0) begin errors++; $display("FAIL idle_operand got %h exp 0", operand); end
    endtask

    task automatic test_single_6();
        int p0;
        p0 = pulses;
        repeat (6) run_scan(16'h0040, 1'b1, 1'b0);
        repeat (4) run_scan(16'h0, 1'b1, 1'b0);
        checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL six_pulses got %0d exp 1", pulses - p0); end
        checks++; if (key_code !== 4'h6) begin errors++; $display("FAIL six_code got %h exp 6", key_code); end
        checks++; if (operand !== 32'h6 || digit_cnt !== 4'd1) begin
            errors++; $display("FAIL six_operand got %h/%0d exp 00000006/1", operand, digit_cnt);
        end
    endtask

    task automatic test_sequence();
        int seq[8] = '{0, 1, 3, 14, 13, 2, 11, 15};
        int p0;
        run_scan(16'h0, 1'b1, 1'b1);
        foreach (seq[i]) press_key(seq[i], 1'b1);
        checks++; if (operand !== 32'h12AF03CD || digit_cnt !== 4'd8 || ovf !== 1'b0) begin
            errors++; $display("FAIL seq_operand got %h/%0d/%b exp 12af03cd/8/0", operand, digit_cnt, ovf);
        end
        p0 = pulses;
        press_key(10, 1'b1);
        checks++; if (pulses - p0 != 1 || key_code !== 4'h9) begin
            errors++; $display("FAIL ninth_key got pulses=%0d code=%h exp 1/9", pulses - p0, key_code);
        end
        checks++; if (operand !== 32'h12AF03CD || ovf !== 1'b1 || digit_cnt !== 4'd8) begin
            errors++; $display("FAIL ninth_ovf got %h/%b/%0d exp 12af03cd/1/8", operand, ovf, digit_cnt);
        end
    endtask

    task automatic test_bounce();
        int p0;
        p0 = pulses;
        repeat (2) run_scan(16'h0020, 1'b0, 1'b0);
        run_scan(16'h0, 1'b0, 1'b0);
        repeat (3) run_scan(16'h0020, 1'b0, 1'b0);
        run_scan(16'h0, 1'b0, 1'b0);
        run_scan(16'h0020, 1'b0, 1'b0);
        repeat (4) run_scan(16'h0, 1'b0, 1'b0);
        checks++; if (pulses - p0 != 1 || key_code !== 4'h5) begin
            errors++; $display("FAIL bounce got pulses=%0d code=%h exp 1/5", pulses - p0, key_code);
        end
    endtask

    task automatic test_multi();
        int p0;
        p0 = pulses;
        repeat (2) run_scan(16'h0201, 1'b0, 1'b0);
        repeat (3) run_scan(16'h0001, 1'b0, 1'b0);
        repeat (3) run_scan(16'h0, 1'b0, 1'b0);
        checks++; if (pulses - p0 != 1 || key_code !== 4'h1) begin
            errors++; $display("FAIL multi got pulses=%0d code=%h exp 1/1", pulses - p0, key_code);
        end
    endtask

    task automatic test_clr_accept();
        repeat (DB) run_scan(16'h0100, 1'b1, 1'b0);
        run_scan(16'h0, 1'b1, 1'b1);
        repeat (3) run_scan(16'h0, 1'b1, 1'b0);
        checks++; if (key_code !== 4'h7 || operand !== 32'h0 || digit_cnt !== 4'd0 || ovf !== 1'b0) begin
            errors++; $display("FAIL clr_accept got code=%h op=%h cnt=%0d ovf=%b exp 7/0/0/0", key_code, operand, digit_cnt, ovf);
        end
    endtask

    task automatic test_reset_hold();
        int p0;
        repeat (DB + 1) run_scan(16'h0010, 1'b1, 1'b0);
        #13 rst_n = 1'b0;
        #1;
        checks++; if (key_row !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0) begin
            errors++; $display("FAIL async_rst_ctl got row=%b kv=%b code=%h exp 1110/0/0", key_row, key_valid, key_code);
        end
        checks++; if (operand !== 32'h0 || digit_cnt !== 4'd0 || ovf !== 1'b0) begin
            errors++; $display("FAIL async_rst_regs got %h/%0d/%b exp 0/0/0", operand, digit_cnt, ovf);
        end
        apply_reset();
        p0 = pulses;
        repeat (DB) run_scan(16'h0010, 1'b1, 1'b0);
        repeat (DB) run_scan(16'h0, 1'b1, 1'b0);
        checks++; if (pulses - p0 != 1 || key_code !== 4'h4 || operand !== 32'h4) begin
            errors++; $display("FAIL reheld got pulses=%0d code=%h op=%h exp 1/4/4", pulses - p0, key_code, operand);
        end
    endtask

    task automatic test_random();
        logic [15:0] pat, prev;
        int          sel, rc, rp;
        prev = '0;
        for (int s = 0; s < 90; s++) begin
            if ($urandom_range(0, 99) < 65) begin
                pat = prev;
            end else begin
                sel = $urandom_range(0, 99);
                if (sel < 40) pat = '0;
                else if (sel < 85) pat = 16'h1 << $urandom_range(0, 15);
                else pat = (16'h1 << $urandom_range(0, 7)) | (16'h100 << $urandom_range(0, 7));
            end
            rc = classify(pat);
            rp = classify(prev);
            if (rc >= 0 && rp >= 0 && rc != rp) pat = '0;
            run_scan(pat, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
            prev = pat;
        end
        repeat (DB + 1) run_scan(16'h0, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_single_6();
        test_sequence();
        test_bounce();
        test_multi();
        test_clr_accept();
        test_reset_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
